// File: rtl/tm_argmax_sequencer.sv
// Time-multiplexed argmax for the Tsetlin Machine back end.
// Snapshots the signed class sums on a rising edge of its_business_time, scans
// them through one shared signed comparator (one class per cycle) and offers
// the winning index as a single-beat AXI-Stream transfer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   c_sum               per-class signed sums (sampled only on the trigger edge)
//   its_business_time   level from the class-sum stage; rising edge = trigger
//   busy                high while scanning or holding a result
//   overrun             sticky: a trigger edge arrived while busy and was dropped
//   m00_axis_*          result stream: tdata = winning index (zero-extended)
//   max_value           winning class sum, valid while tvalid
module tm_argmax_sequencer #(
  parameter int unsigned CLASS_NUM              = 10,
  parameter int unsigned WEIGHT_LENGTH          = 14,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [WEIGHT_LENGTH-1:0]       c_sum [CLASS_NUM],
  input  logic                                  its_business_time,
  output logic                                  busy,
  output logic                                  overrun,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tlast,
  output logic signed [WEIGHT_LENGTH-1:0]       max_value
);

  localparam int unsigned INDEX_LENGTH = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
  localparam logic [INDEX_LENGTH-1:0] LAST_IDX = INDEX_LENGTH'(CLASS_NUM - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic signed [WEIGHT_LENGTH-1:0]   snap_q [CLASS_NUM];
  logic signed [WEIGHT_LENGTH-1:0]   snap_d [CLASS_NUM];
  logic signed [WEIGHT_LENGTH-1:0]   best_val_q, best_val_d;
  logic [INDEX_LENGTH-1:0]           best_idx_q, best_idx_d;
  logic [INDEX_LENGTH-1:0]           idx_q, idx_d;
  logic                              its_q, its_d;
  logic                              busy_q, busy_d;
  logic                              overrun_q, overrun_d;
  logic                              tvalid_q, tvalid_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic signed [WEIGHT_LENGTH-1:0]   max_value_q, max_value_d;

  logic                              trig;
  logic signed [WEIGHT_LENGTH-1:0]   cur_val;

  // Snapshot entry under the scan pointer; a mux loop keeps the select
  // well-formed when CLASS_NUM is not a power of two (or is 1).
  always_comb begin
    cur_val = snap_q[0];
    for (int i = 0; i < CLASS_NUM; i++) begin
      if (idx_q == INDEX_LENGTH'(i)) cur_val = snap_q[i];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    its_d       = its_business_time;
    overrun_d   = overrun_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    max_value_d = max_value_q;

    trig = its_business_time & ~its_q;

    // Any trigger outside IDLE (including the DONE handshake cycle) is dropped.
    if (trig && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          snap_d     = c_sum;
          best_val_d = c_sum[0];
          best_idx_d = '0;
          idx_d      = INDEX_LENGTH'(1);
          state_d    = (CLASS_NUM == 1) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        // Strictly greater: ties keep the lower index.
        if (cur_val > best_val_q) begin
          best_val_d = cur_val;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + INDEX_LENGTH'(1);
      end
      S_DONE: begin
        if (tvalid_q && m00_axis_tready) begin
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
        end else begin
          tvalid_d    = 1'b1;
          tdata_d     = C_M00_AXIS_TDATA_WIDTH'(best_idx_q);
          max_value_d = best_val_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < CLASS_NUM; i++) snap_q[i] <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      its_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      max_value_q <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      its_q       <= its_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      max_value_q <= max_value_d;
    end
  end

  assign busy            = busy_q;
  assign overrun         = overrun_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign max_value       = max_value_q;

endmodule

// File: tb/tb_tm_argmax_sequencer.sv
// Self-checking bench for tm_argmax_sequencer (CLASS_NUM=10 and CLASS_NUM=1).
module tb_tm_argmax_sequencer;

  localparam int unsigned CN = 10;
  localparam int unsigned W  = 14;
  localparam int unsigned DW = 64;

  logic                clk;
  logic                rst;
  logic signed [W-1:0] c_sum [CN];
  logic                its;
  logic                tready;
  logic                busy, overrun, tvalid, tlast;
  logic [DW-1:0]       tdata;
  logic signed [W-1:0] max_value;

  logic signed [W-1:0] c1_sum [1];
  logic                its1, tready1;
  logic                busy1, overrun1, tvalid1, tlast1;
  logic [DW-1:0]       tdata1;
  logic signed [W-1:0] max1;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;
  int                  exp_idx_q [$];
  logic signed [W-1:0] exp_val_q [$];

  tm_argmax_sequencer #(.CLASS_NUM(CN), .WEIGHT_LENGTH(W), .C_M00_AXIS_TDATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .c_sum(c_sum), .its_business_time(its),
    .busy(busy), .overrun(overrun),
    .m00_axis_tvalid(tvalid), .m00_axis_tready(tready),
    .m00_axis_tdata(tdata), .m00_axis_tlast(tlast), .max_value(max_value)
  );

  tm_argmax_sequencer #(.CLASS_NUM(1), .WEIGHT_LENGTH(W), .C_M00_AXIS_TDATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst(rst), .c_sum(c1_sum), .its_business_time(its1),
    .busy(busy1), .overrun(overrun1),
    .m00_axis_tvalid(tvalid1), .m00_axis_tready(tready1),
    .m00_axis_tdata(tdata1), .m00_axis_tlast(tlast1), .max_value(max1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax: find the maximum, then the first index holding it.
  task automatic push_ref();
    logic signed [W-1:0] mx;
    int                  bi;
    mx = c_sum[0];
    for (int i = 1; i < CN; i++) if (c_sum[i] > mx) mx = c_sum[i];
    bi = -1;
    for (int i = CN - 1; i >= 0; i--) if (c_sum[i] == mx) bi = i;
    exp_idx_q.push_back(bi);
    exp_val_q.push_back(mx);
  endtask

  task automatic rand_sums(input bit narrow);
    for (int i = 0; i < CN; i++)
      c_sum[i] = narrow ? W'($signed($urandom_range(0, 7)) - 4) : W'($urandom);
  endtask

  // Trigger a classification and wait for tvalid; leaves tvalid high on return.
  task automatic classify(input int exp_lat, input int retrig, input bit scramble);
    int n;
    push_ref();
    its = 1'b1;
    n   = 0;
    do begin
      cyc();
      n++;
      its = 1'b0;
      if (scramble) rand_sums(1'b0);
      if (n == retrig) begin
        rand_sums(1'b0);
        c_sum[5] = 14'sd8191;
        its = 1'b1;
      end
    end while (!tvalid && n < 64);
    check("latency", 64'(n - 1), 64'(exp_lat));
  endtask

  // Scoreboard: compare every accepted beat against the queued reference.
  always @(negedge clk) begin
    if (!rst && tvalid) begin
      check("tlast", 64'(tlast), 64'(1));
      if (tready) begin
        beats++;
        if (exp_idx_q.size() == 0) begin
          check("spurious_beat", 64'(1), 64'(0));
        end else begin
          check("sb_tdata", tdata, 64'(exp_idx_q.pop_front()));
          check("sb_max_value", 64'(max_value), 64'(exp_val_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int cnt;
    int b0;
    rst = 1'b1; its = 1'b0; tready = 1'b1;
    its1 = 1'b0; tready1 = 1'b1; c1_sum[0] = -14'sd77;
    for (int i = 0; i < CN; i++) c_sum[i] = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_tdata", tdata, 64'(0));
    check("rst_max_value", 64'(max_value), 64'(0));
    check("rst_tvalid1", 64'(tvalid1), 64'(0));
    cyc();
    rst = 1'b0;
    cyc();

    // Reset in the middle of a scan.
    c_sum = '{14'sd5, -14'sd3, 14'sd12, 14'sd7, 14'sd12, 14'sd0, -14'sd8, 14'sd1, 14'sd2, 14'sd11};
    its = 1'b1;
    cyc();
    its = 1'b0;
    repeat (3) cyc();
    check("mid_busy_pre", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_overrun", 64'(overrun), 64'(0));
    exp_idx_q.delete();
    exp_val_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
    classify(CN, -1, 1'b0);
    check("tie_tdata", tdata, 64'(2));
    check("tie_max_value", 64'(max_value), 64'(12));
    cyc();
    check("tie_drop", 64'(tvalid), 64'(0));

    // Backpressure: result held stable while tready is low.
    for (int i = 0; i < CN; i++) c_sum[i] = '0;
    c_sum[7] = 14'sd100;
    tready = 1'b0;
    classify(CN, -1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("bp_tvalid", 64'(tvalid), 64'(1));
      check("bp_tdata", tdata, 64'(7));
      check("bp_max_value", 64'(max_value), 64'(100));
    end
    tready = 1'b1;
    cyc();
    check("bp_drop", 64'(tvalid), 64'(0));
    check("bp_tdata_kept", tdata, 64'(7));

    // Signed extremes.
    for (int i = 0; i < CN; i++) c_sum[i] = -14'sd8192;
    classify(CN, -1, 1'b0);
    check("neg_tdata", tdata, 64'(0));
    check("neg_max_value", 64'(max_value), 64'(-8192));
    cyc();
    for (int i = 0; i < CN; i++) c_sum[i] = '0;
    c_sum[0] = -14'sd8192;
    c_sum[9] = 14'sd8191;
    classify(CN, -1, 1'b0);
    check("pos_tdata", tdata, 64'(9));
    check("pos_max_value", 64'(max_value), 64'(8191));
    cyc();

    // Overrun: retrigger during scan and on the handshake cycle.
    for (int i = 0; i < CN; i++) c_sum[i] = W'(i * 3 - 10);
    classify(CN, 3, 1'b0);
    check("ovr_tdata", tdata, 64'(9));
    its = 1'b1;
    cyc();
    its = 1'b0;
    check("ovr_flag", 64'(overrun), 64'(1));
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (tvalid) cnt++;
    end
    check("ovr_no_second", 64'(cnt), 64'(0));
    check("ovr_sticky", 64'(overrun), 64'(1));

    // Level trigger held high: exactly one result.
    rand_sums(1'b1);
    push_ref();
    b0  = beats;
    its = 1'b1;
    repeat (50) cyc();
    its = 1'b0;
    repeat (3) cyc();
    check("level_beats", 64'(beats - b0), 64'(1));

    // CLASS_NUM = 1.
    its1 = 1'b1;
    cnt  = 0;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      if (k == 1) check("cn1_pre", 64'(tvalid1), 64'(0));
      if (k == 2) begin
        check("cn1_tvalid", 64'(tvalid1), 64'(1));
        check("cn1_tdata", tdata1, 64'(0));
        check("cn1_max_value", 64'(max1), 64'(-77));
      end
      if (tvalid1) cnt++;
    end
    its1 = 1'b0;
    check("cn1_beats", 64'(cnt), 64'(1));

    // Snapshot isolation over random runs.
    for (int r = 0; r < 1000; r++) begin
      rand_sums(r[0]);
      classify(CN, -1, 1'b1);
      cyc();
    end

    repeat (3) cyc();
    check("sb_empty", 64'(exp_idx_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
